fixed_point_calc_4bit: RTL and testbench
========================================

Name: fixed_point_calc_4bit

Overview:
- 4-bit unsigned calculator for a DE-series FPGA board with slide switches, four active-low push-buttons and six 7-segment displays.
- Operand A comes from SW[3:0] and operand B from SW[7:4]. Each push-button selects one operation: ADD, SUB, MUL or DIV.
- Operands appear on HEX5/HEX4. The signed or fixed-point result appears in decimal on HEX3..HEX0.
- Top-level board block: inputs are synchronized and all state is registered.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on SW and KEY (minimum 2).

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- SW  in  10  SW[3:0]=A, SW[7:4]=B, SW[9:8] unused.
- KEY  in  4  active-low buttons: KEY[0]=ADD, KEY[1]=SUB, KEY[2]=MUL, KEY[3]=DIV.
- HEX0..HEX5  out  7 each  active-low segments, bit0=a … bit6=g.

Behaviour:
- Synchronization: SW and KEY each pass through SYNC_STAGES flops before use.
- Level-sensitive operation:
  - On every clock where any synchronized KEY bit is 0, capture A, B and the op.
  - Priority when several keys are held: ADD > SUB > MUL > DIV.
  - The result updates every cycle while a key is held, so SW changes under a held key are tracked.
  - With all keys released, the last A, B, op and result are held.
- Latency: the result and all HEX registers reflect an input change SYNC_STAGES+1 clocks later (3 by default). Segment outputs are registered.
- Reset:
  - Synchronizers are cleared to SW=0 and KEY=1111.
  - Op becomes NONE.
  - All HEX outputs become blank (7'b1111111).
  - Reset overrides a held key; capture resumes on the first non-reset cycle.
- Arithmetic, unsigned 4-bit operands:
  - ADD: A+B, 5-bit, range 0..30.
  - SUB: A−B as sign plus magnitude. Negative if B>A; magnitude |A−B|, range 0..15.
  - MUL: A*B, 8-bit, range 0..225.
  - DIV, B≠0: fixed-point quotient with one decimal fraction digit.
    - Integer part q = A/B (0..15).
    - Tenths digit t = (A mod B)*10/B, truncated.
  - DIV, B=0: error.
- Display:
  - HEX5 = hex glyph of captured A; HEX4 = hex glyph of captured B. Both are blank when op=NONE.
  - HEX3 = '-' (7'b0111111) for a negative SUB result, 'E' (7'b0000110) for divide-by-zero, otherwise blank.
  - ADD/SUB/MUL: magnitude in decimal on HEX2 (hundreds), HEX1 (tens), HEX0 (units). Leading zeros are blanked; HEX0 is always lit.
  - DIV: HEX2 = tens of q (blank if 0), HEX1 = units of q (always lit), HEX0 = t.
  - Divide-by-zero: HEX2..HEX0 blank.
  - A zero result shows '0' on HEX0; no minus sign for zero.
- Glyphs, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Binary-to-BCD conversion: combinational, e.g. double-dabble, within the result register stage.

Decomposition:
- Package fixed_point_calc_pkg:
  - Op enum: NONE, ADD, SUB, MUL, DIV.
  - Segment constants: SEG_BLANK, SEG_MINUS, SEG_E.
  - 16-entry hex glyph table.
- One sub-module calc_seg7_decoder: 4-bit digit plus blank flag in, 7-bit active-low segments out. Instantiated six times.
- Synchronizer and BCD conversion stay in the top module.

Test Plan:
- Reset asserted for 2 clocks, then released with KEY=1111 → all HEX = 1111111.
- SW[3:0]=5, SW[7:4]=3, KEY=1110, wait ≥3 clocks → HEX5='5', HEX4='3', HEX3..HEX1 blank, HEX0='8'.
- A=3, B=5, KEY=1101 → HEX3='-', HEX0='2'. Then A=4, B=2, KEY=1011 → HEX0='8', HEX3 blank.
- A=9, B=3, KEY=0111 → HEX1='3', HEX0='0'. Keep KEY held, change to A=7, B=0 → HEX3='E', HEX2..HEX0 blank (level tracking).
- A=15, B=1, KEY=1110 → HEX5='F', HEX1='1', HEX0='6'. Then A=15, B=15, KEY=1011 → HEX2='2', HEX1='2', HEX0='5'.
- A=7, B=2, KEY=0110 (ADD and DIV both held) → ADD wins, HEX0='9'. Release all keys and change SW → display unchanged. Assert RESET mid-hold → all HEX blank on the next edge.

Source files
------------

// File: rtl/fixed_point_calc_pkg.sv
// Shared types and seven-segment constants for the 4-bit fixed-point calculator.
// Segment vectors are active-low with bit0 = a ... bit6 = g.
package fixed_point_calc_pkg;

   typedef enum logic [2:0] {
      NONE = 3'd0,
      ADD  = 3'd1,
      SUB  = 3'd2,
      MUL  = 3'd3,
      DIV  = 3'd4
   } op_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;

   localparam logic [6:0] HEX_GLYPH [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

endpackage

// File: rtl/calc_seg7_decoder.sv
// One 7-segment digit: hex glyph lookup with a blank override.
module calc_seg7_decoder
   import fixed_point_calc_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_BLANK : HEX_GLYPH[digit];

endmodule

// File: rtl/fixed_point_calc_4bit.sv
// Board-level 4-bit calculator: synchronized switches/keys, one registered result
// stage that captures operands while a key is held and drives six 7-segment digits.
module fixed_point_calc_4bit
   import fixed_point_calc_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic [9:0] SW,
   input  logic [3:0] KEY,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);

   logic [SYNC_STAGES-1:0][7:0] sw_sync;
   logic [SYNC_STAGES-1:0][3:0] key_sync;
   logic [7:0] sw_s;
   logic [3:0] key_s;

   logic       unused_sw;
   assign unused_sw = ^SW[9:8];

   // NOTE: registered state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the synchronizer chain.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         sw_sync  <= '0;
         key_sync <= '1;
      end else begin
         sw_sync  <= {sw_sync[SYNC_STAGES-2:0], SW[7:0]};
         key_sync <= {key_sync[SYNC_STAGES-2:0], KEY};
      end
   end

   assign sw_s  = sw_sync[SYNC_STAGES-1];
   assign key_s = key_sync[SYNC_STAGES-1];

   op_t        op_q, op_n;
   logic [3:0] a_q, b_q, a_n, b_n;

   // Released keys leave the next-state equal to the held state, so the display holds.
   always_comb begin
      op_n = op_q;
      a_n  = a_q;
      b_n  = b_q;
      if (key_s != 4'b1111) begin
         a_n = sw_s[3:0];
         b_n = sw_s[7:4];
         if      (!key_s[0]) op_n = ADD;
         else if (!key_s[1]) op_n = SUB;
         else if (!key_s[2]) op_n = MUL;
         else                op_n = DIV;
      end
   end

   function automatic logic [11:0] bin2bcd(input logic [7:0] bin);
      logic [11:0] bcd;
      bcd = '0;
      for (int i = 7; i >= 0; i--) begin
         if (bcd[3:0]  >= 4'd5) bcd[3:0]  = bcd[3:0]  + 4'd3;
         if (bcd[7:4]  >= 4'd5) bcd[7:4]  = bcd[7:4]  + 4'd3;
         if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
         bcd = {bcd[10:0], bin[i]};
      end
      return bcd;
   endfunction

   logic [3:0] div_safe, quo, rem;
   logic [7:0] tenths_w;
   logic       unused_div;

   // Substitute divisor 1 on B=0 so the datapath never divides by zero.
   assign div_safe   = (b_n == 4'd0) ? 4'd1 : b_n;
   assign quo        = a_n / div_safe;
   assign rem        = a_n % div_safe;
   assign tenths_w   = ({4'd0, rem} * 8'd10) / {4'd0, div_safe};
   assign unused_div = ^tenths_w[7:4];

   logic [3:0]  dig [6];
   logic        blk [6];
   logic [6:0]  seg [6];
   logic [7:0]  mag;
   logic [11:0] bcd;
   logic        neg, err;
   logic [6:0]  hex3_n;

   always_comb begin
      for (int i = 0; i < 6; i++) begin
         dig[i] = 4'd0;
         blk[i] = 1'b1;
      end
      mag = 8'd0;
      neg = 1'b0;
      err = 1'b0;
      dig[5] = a_n;
      dig[4] = b_n;
      blk[5] = (op_n == NONE);
      blk[4] = (op_n == NONE);
      case (op_n)
         ADD:     mag = {4'd0, a_n} + {4'd0, b_n};
         SUB: begin
            neg = (b_n > a_n);
            mag = neg ? {4'd0, b_n - a_n} : {4'd0, a_n - b_n};
         end
         MUL:     mag = {4'd0, a_n} * {4'd0, b_n};
         default: mag = {4'd0, quo};
      endcase
      bcd = bin2bcd(mag);
      if (op_n == ADD || op_n == SUB || op_n == MUL) begin
         dig[2] = bcd[11:8];
         dig[1] = bcd[7:4];
         dig[0] = bcd[3:0];
         blk[2] = (bcd[11:8] == 4'd0);
         blk[1] = (bcd[11:4] == 8'd0);
         blk[0] = 1'b0;
      end else if (op_n == DIV) begin
         if (b_n == 4'd0) begin
            err = 1'b1;
         end else begin
            dig[2] = bcd[7:4];
            dig[1] = bcd[3:0];
            dig[0] = tenths_w[3:0];
            blk[2] = (bcd[7:4] == 4'd0);
            blk[1] = 1'b0;
            blk[0] = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < 6; g++) begin : g_dec
      calc_seg7_decoder u_dec (
         .digit (dig[g]),
         .blank (blk[g]),
         .seg   (seg[g])
      );
   end

   assign hex3_n = neg ? SEG_MINUS : (err ? SEG_E : seg[3]);

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         op_q <= NONE;
         a_q  <= 4'd0;
         b_q  <= 4'd0;
         HEX0 <= SEG_BLANK;
         HEX1 <= SEG_BLANK;
         HEX2 <= SEG_BLANK;
         HEX3 <= SEG_BLANK;
         HEX4 <= SEG_BLANK;
         HEX5 <= SEG_BLANK;
      end else begin
         op_q <= op_n;
         a_q  <= a_n;
         b_q  <= b_n;
         HEX0 <= seg[0];
         HEX1 <= seg[1];
         HEX2 <= seg[2];
         HEX3 <= hex3_n;
         HEX4 <= seg[4];
         HEX5 <= seg[5];
      end
   end

endmodule

// File: tb/tb_fixed_point_calc_4bit.sv
// Scoreboard bench for fixed_point_calc_4bit: each stimulus pushes the expected
// six-digit display, which a negedge monitor pops and compares when it falls due.
module tb_fixed_point_calc_4bit;

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] MN = 7'b0111111;
   localparam logic [6:0] EE = 7'b0000110;
   localparam logic [6:0] G [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] sw  = '0;
   logic [3:0] key = 4'b1111;
   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

   fixed_point_calc_4bit #(.SYNC_STAGES(2)) dut (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .SW       (sw),
      .KEY      (key),
      .HEX0     (hex0),
      .HEX1     (hex1),
      .HEX2     (hex2),
      .HEX3     (hex3),
      .HEX4     (hex4),
      .HEX5     (hex5)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [41:0] exp;
      string       tag;
   } exp_t;

   exp_t sb [$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_op = 0, m_a = 0, m_b = 0;   // 0=none 1=add 2=sub 3=mul 4=div

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [41:0] model(input int op, input int a, input int b);
      logic [6:0] h [6];
      int v, q, t;
      for (int i = 0; i < 6; i++) h[i] = BL;
      if (op != 0) begin
         h[5] = G[a];
         h[4] = G[b];
         if (op == 4) begin
            if (b == 0) h[3] = EE;
            else begin
               q = a / b;
               t = ((a % b) * 10) / b;
               if (q >= 10) h[2] = G[q / 10];
               h[1] = G[q % 10];
               h[0] = G[t];
            end
         end else begin
            if (op == 1)      v = a + b;
            else if (op == 2) v = (a >= b) ? a - b : b - a;
            else              v = a * b;
            if (op == 2 && b > a) h[3] = MN;
            if (v >= 100) h[2] = G[v / 100];
            if (v >= 10)  h[1] = G[(v / 10) % 10];
            h[0] = G[v % 10];
         end
      end
      return {h[5], h[4], h[3], h[2], h[1], h[0]};
   endfunction

   task automatic push(input int due, input string tag);
      exp_t e;
      e.due = due;
      e.exp = model(m_op, m_a, m_b);
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Drive one input vector, update the model and wait out the pipeline.
   task automatic step(input int a, input int b, input logic [3:0] k, input string tag);
      @(negedge clk);
      #1;
      sw  = {2'b00, b[3:0], a[3:0]};
      key = k;
      if (k != 4'b1111) begin
         m_a = a;
         m_b = b;
         if      (!k[0]) m_op = 1;
         else if (!k[1]) m_op = 2;
         else if (!k[2]) m_op = 3;
         else            m_op = 4;
      end
      push(cyc + 3, tag);
      repeat (3) @(negedge clk);
   endtask

   initial begin : monitor
      exp_t        e;
      logic [41:0] got;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e   = sb.pop_front();
            got = {hex5, hex4, hex3, hex2, hex1, hex0};
            for (int i = 0; i < 6; i++)
               check($sformatf("%s.HEX%0d", e.tag, i), 32'(got[i*7 +: 7]), 32'(e.exp[i*7 +: 7]));
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      push(cyc + 1, "reset");
      repeat (2) @(negedge clk);

      step(5, 3, 4'b1110, "add_5_3");
      step(3, 5, 4'b1101, "sub_neg");
      step(4, 2, 4'b1011, "mul_4_2");
      step(9, 3, 4'b0111, "div_9_3");
      step(7, 2, 4'b0111, "div_7_2");
      step(7, 0, 4'b0111, "div_by_0");
      step(15, 1, 4'b0111, "div_15_1");
      step(15, 1, 4'b1110, "add_15_1");
      step(15, 15, 4'b1011, "mul_15_15");
      step(6, 6, 4'b1101, "sub_zero");
      step(12, 4, 4'b1101, "sub_pos");
      step(7, 2, 4'b0110, "prio_add");
      step(1, 1, 4'b1111, "hold");
      step(4, 4, 4'b1110, "add_4_4");

      // Reset under a held key: blank at once, capture resumes after the synchronizer refills.
      @(negedge clk);
      #1;
      rst  = 1'b1;
      m_op = 0;
      push(cyc + 1, "rst_hold1");
      push(cyc + 2, "rst_hold2");
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      push(cyc + 1, "post_rst1");
      push(cyc + 2, "post_rst2");
      m_a  = 4;
      m_b  = 4;
      m_op = 1;
      push(cyc + 3, "post_rst_add");
      repeat (3) @(negedge clk);

      for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
      #1;
      check("drain", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
